// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width and capture FSM encodings for the uart receive path
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT = 2'd2} cap_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO with wrapping AW+1 bit pointers
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = BYTE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  logic [AW:0]  wr, rd;
  logic [W-1:0] mem [DEPTH];
  assign empty   = wr == rd;
  assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign count   = wr - rd;
  assign rd_data = mem[rd[AW-1:0]];
  // pointers advance on accepted push/pop; a pop on an empty FIFO is ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (wr_en) wr <= wr + (AW+1)'(1);
      if (rd_en && !empty) rd <= rd + (AW+1)'(1);
    end
  // storage is not reset; only slots between the pointers are ever read
  always_ff @(posedge clk)
    if (wr_en) mem[wr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: acks uart bytes and buffers them in a FWFT FIFO; UART_RXF_OVR_CNT_EN adds ovr_cnt
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              uart_rdy,
  input  logic [BYTE_W-1:0] uart_dout,
  output logic              uart_rdy_clr,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef UART_RXF_OVR_CNT_EN
  ,
  output logic [7:0]        ovr_cnt
`endif
);
  cap_state_t state, state_n;
  logic capture, pop, drop, empty;
  assign capture = (state == IDLE) && uart_rdy;
  assign pop     = m_valid && m_ready;
  assign drop    = capture && full && !pop;
  assign m_valid = !empty;
  // capture once on rdy, ack for one cycle, then wait for the uart to drop rdy
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? (uart_rdy ? ACK : IDLE) :
              (state == ACK)  ? WAIT :
              (uart_rdy ? WAIT : IDLE);
  end
  // state register with the ack pulse registered alongside it
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      uart_rdy_clr <= 1'b0;
    end else begin
      state        <= state_n;
      uart_rdy_clr <= state_n == ACK;
    end
  // sticky overrun flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) overrun <= 1'b0;
    else overrun <= drop || (overrun && !ovr_clr);
`ifdef UART_RXF_OVR_CNT_EN
  // saturating count of dropped bytes; clear together with a drop loads one
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) ovr_cnt <= 8'd0;
    else if (ovr_clr) ovr_cnt <= {7'd0, drop};
    else if (drop && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
`endif
  uart_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(BYTE_W)) u_fifo (
    .clk    (clk_50m),
    .rst_n  (rst_n),
    .wr_en  (capture && !drop),
    .wr_data(uart_dout),
    .rd_en  (pop),
    .rd_data(m_data),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );
endmodule
